// File: rtl/sme_job_arbiter.sv
// sme_job_arbiter: round-robin front end sharing one SME string-match engine
// between NREQ requesters. It grants one job at a time and forwards the
// winner's characters to the engine. It then waits for the engine result
// (bounded by a timeout) and returns match/index/err to the owner.
module sme_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   gnt_o,
  input  logic [NREQ-1:0]   char_valid_i,
  input  logic [NREQ-1:0]   char_is_str_i,
  input  logic [8*NREQ-1:0] char_data_i,
  input  logic [NREQ-1:0]   char_last_i,
  output logic [7:0]        sme_chardata_o,
  output logic              sme_isstring_o,
  output logic              sme_ispattern_o,
  input  logic              sme_valid_i,
  input  logic              sme_match_i,
  input  logic [4:0]        sme_index_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic              rsp_match_o,
  output logic [4:0]        rsp_index_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STRW = $clog2(MAX_STR + 1);
  localparam int PATW = $clog2(MAX_PAT + 1);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_STREAM, S_WAIT_RES, S_RESP} state_e;

  state_e            state_q;
  logic [SW-1:0]     rr_q, sel_q;
  logic [STRW-1:0]   str_cnt_q;
  logic [PATW-1:0]   pat_cnt_q;
  logic              seen_pat_q, err_q;
  logic              res_valid_q;
  logic [SW-1:0]     res_owner_q;
  logic [TW-1:0]     timer_q;
  logic [NREQ-1:0]   gnt_q, rsp_valid_q;
  logic              rsp_match_q, rsp_err_q;
  logic [4:0]        rsp_index_q;
  logic [7:0]        sme_chardata_q;
  logic              sme_isstring_q, sme_ispattern_q;

  logic              pick_hit;
  logic [SW-1:0]     pick;
  logic              cv, cs, cl;
  logic [7:0]        cd;
  logic              str_full, pat_full, drop, acc, end_job, job_err;
  logic [STRW-1:0]   str_cnt_d;
  logic [PATW-1:0]   pat_cnt_d;

  // First pending requester at or after the round-robin pointer.
  always_comb begin
    pick_hit = 1'b0;
    pick     = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_hit && req_i[(int'(rr_q) + k) % NREQ]) begin
        pick_hit = 1'b1;
        pick     = SW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  // Granted lane's character inputs and the per-character accept/drop decision.
  always_comb begin
    cv        = char_valid_i[sel_q];
    cs        = char_is_str_i[sel_q];
    cl        = char_last_i[sel_q];
    cd        = char_data_i[{sel_q, 3'b000} +: 8];
    str_full  = (str_cnt_q == STRW'(MAX_STR));
    pat_full  = (pat_cnt_q == PATW'(MAX_PAT));
    // A string char after the pattern started would corrupt the engine's string.
    drop      = cs ? (seen_pat_q || str_full) : pat_full;
    acc       = cv && !drop;
    str_cnt_d = str_cnt_q + STRW'(acc && cs);
    pat_cnt_d = pat_cnt_q + PATW'(acc && !cs);
    end_job   = !cv || cl;
    // A pattern-only job is legal only against a string this requester loaded.
    job_err   = (pat_cnt_d == '0) ||
                ((str_cnt_d == '0) && !(res_valid_q && (res_owner_q == sel_q)));
  end

  // Job FSM with registered grant, engine and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rr_q            <= '0;
      sel_q           <= '0;
      str_cnt_q       <= '0;
      pat_cnt_q       <= '0;
      seen_pat_q      <= 1'b0;
      err_q           <= 1'b0;
      res_valid_q     <= 1'b0;
      res_owner_q     <= '0;
      timer_q         <= '0;
      gnt_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_match_q     <= 1'b0;
      rsp_index_q     <= '0;
      rsp_err_q       <= 1'b0;
      sme_chardata_q  <= '0;
      sme_isstring_q  <= 1'b0;
      sme_ispattern_q <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_hit) begin
            sel_q   <= pick;
            gnt_q   <= NREQ'(1) << pick;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          rr_q       <= (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
          str_cnt_q  <= '0;
          pat_cnt_q  <= '0;
          seen_pat_q <= 1'b0;
          err_q      <= 1'b0;
          state_q    <= S_STREAM;
        end
        S_STREAM: begin
          sme_isstring_q  <= acc && cs;
          sme_ispattern_q <= acc && !cs;
          if (acc) sme_chardata_q <= cd;
          str_cnt_q <= str_cnt_d;
          pat_cnt_q <= pat_cnt_d;
          if (acc && !cs) seen_pat_q <= 1'b1;
          if ((cv && drop) || (end_job && (!cv || job_err))) err_q <= 1'b1;
          if (end_job) begin
            timer_q <= '0;
            state_q <= S_WAIT_RES;
            if (str_cnt_d != '0) begin
              res_owner_q <= sel_q;
              res_valid_q <= 1'b1;
            end
          end
        end
        S_WAIT_RES: begin
          // Dropping both strobes tells the engine the data has ended.
          sme_isstring_q  <= 1'b0;
          sme_ispattern_q <= 1'b0;
          if (sme_valid_i) begin
            rsp_valid_q <= NREQ'(1) << sel_q;
            rsp_match_q <= sme_match_i;
            rsp_index_q <= sme_index_i;
            rsp_err_q   <= err_q;
            state_q     <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            // The engine state is now unknown, so the resident string is too.
            rsp_valid_q <= NREQ'(1) << sel_q;
            rsp_match_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_err_q   <= 1'b1;
            res_valid_q <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o           = gnt_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_match_o     = rsp_match_q;
  assign rsp_index_o     = rsp_index_q;
  assign rsp_err_o       = rsp_err_q;
  assign sme_chardata_o  = sme_chardata_q;
  assign sme_isstring_o  = sme_isstring_q;
  assign sme_ispattern_o = sme_ispattern_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sme_job_arbiter.sv
// Bench for sme_job_arbiter: a table of directed jobs plus hand-written
// sequences for round-robin order, timeout and reset during a job.
// A small behavioural SME engine model produces match results.
module tb_sme_job_arbiter;
  localparam int NREQ = 2, MAX_STR = 32, MAX_PAT = 8, TO = 16;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req = '0, char_valid = '0, char_is_str = '0, char_last = '0;
  logic [8*NREQ-1:0] char_data = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [7:0]        sme_chardata;
  logic              sme_isstring, sme_ispattern, rsp_match, rsp_err, busy;
  logic              sme_valid, sme_match;
  logic [4:0]        sme_index, rsp_index;

  sme_job_arbiter #(.NREQ(NREQ), .MAX_STR(MAX_STR), .MAX_PAT(MAX_PAT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_i(req), .gnt_o(gnt),
    .char_valid_i(char_valid), .char_is_str_i(char_is_str), .char_data_i(char_data),
    .char_last_i(char_last), .sme_chardata_o(sme_chardata), .sme_isstring_o(sme_isstring),
    .sme_ispattern_o(sme_ispattern), .sme_valid_i(sme_valid), .sme_match_i(sme_match),
    .sme_index_i(sme_index), .rsp_valid_o(rsp_valid), .rsp_match_o(rsp_match),
    .rsp_index_o(rsp_index), .rsp_err_o(rsp_err), .busy_o(busy));

  // Engine model: collects string/pattern runs and answers after a pattern run ends.
  logic [7:0] m_str [0:63];
  logic [7:0] m_pat [0:15];
  int   m_slen, m_plen;
  logic m_ps, m_pp;
  bit   m_en = 1'b1;

  function automatic logic [5:0] find();
    bit ok;
    if (m_plen == 0) return 6'd0;
    for (int i = 0; i + m_plen <= m_slen; i++) begin
      ok = 1'b1;
      for (int j = 0; j < m_plen; j++) if (m_str[i+j] != m_pat[j]) ok = 1'b0;
      if (ok) return {1'b1, 5'(i)};
    end
    return 6'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_slen <= 0; m_plen <= 0; m_ps <= 1'b0; m_pp <= 1'b0;
      sme_valid <= 1'b0; sme_match <= 1'b0; sme_index <= '0;
    end else begin
      m_ps <= sme_isstring;
      m_pp <= sme_ispattern;
      sme_valid <= 1'b0;
      if (sme_isstring) begin
        if (!m_ps) begin m_str[0] <= sme_chardata; m_slen <= 1; end
        else if (m_slen < 64) begin m_str[m_slen] <= sme_chardata; m_slen <= m_slen + 1; end
      end
      if (sme_ispattern) begin
        if (!m_pp) begin m_pat[0] <= sme_chardata; m_plen <= 1; end
        else if (m_plen < 16) begin m_pat[m_plen] <= sme_chardata; m_plen <= m_plen + 1; end
      end
      if (!sme_isstring && !sme_ispattern && m_pp && m_en) begin
        sme_valid <= 1'b1;
        {sme_match, sme_index} <= find();
      end
    end
  end

  // Strobe monitor: cycles of each strobe and number of string runs.
  int   mon_str = 0, mon_pat = 0, mon_rise = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (sme_isstring) mon_str <= mon_str + 1;
    if (sme_ispattern) mon_pat <= mon_pat + 1;
    if (sme_isstring && !mon_prev) mon_rise <= mon_rise + 1;
    mon_prev <= sme_isstring;
  end

  int nchk = 0, nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    int id; int slen; logic [8*40-1:0] s; int plen; logic [8*8-1:0] p;
    int cut; int fs; int fp; int em; int ei; int ee;
  } job_t;

  function automatic job_t mk(int id, int slen, logic [8*40-1:0] s, int plen,
                              logic [8*8-1:0] p, int cut, int fs, int fp, int em, int ei, int ee);
    job_t j;
    j.id = id; j.slen = slen; j.s = s; j.plen = plen; j.p = p; j.cut = cut;
    j.fs = fs; j.fp = fp; j.em = em; j.ei = ei; j.ee = ee;
    return j;
  endfunction

  // Drive the granted lane; the other lanes carry noise that must be ignored.
  task automatic drive(input int id, input logic isstr, input logic [7:0] d, input logic last);
    for (int i = 0; i < NREQ; i++) begin
      char_valid[i] = 1'b1; char_is_str[i] = 1'b1; char_data[8*i +: 8] = 8'hEE; char_last[i] = 1'b1;
    end
    char_valid[id] = 1'b1; char_is_str[id] = isstr; char_data[8*id +: 8] = d; char_last[id] = last;
  endtask

  task automatic lanes_idle();
    char_valid = '0; char_is_str = '0; char_last = '0; char_data = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " gnt"}, int'(gnt), 0);
    chk({tag, " rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, " rsp_match"}, int'(rsp_match), 0);
    chk({tag, " rsp_index"}, int'(rsp_index), 0);
    chk({tag, " rsp_err"}, int'(rsp_err), 0);
    chk({tag, " sme_strobes"}, int'({sme_isstring, sme_ispattern}), 0);
    chk({tag, " sme_chardata"}, int'(sme_chardata), 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  task automatic run_job(input job_t j, input string tag, output int wc);
    int s0, p0, r0, n;
    bit got;
    s0 = mon_str; p0 = mon_pat; r0 = mon_rise; wc = 0;
    req[j.id] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk({tag, " gnt"}, int'(gnt), 1 << j.id);
    req[j.id] = 1'b0;
    if (!got) return;
    n = (j.cut > 0) ? j.cut : j.slen + j.plen;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, " gnt_pulse"}, int'(gnt), 0);
      if (k < j.slen) drive(j.id, 1'b1, j.s[8*(j.slen-1-k) +: 8], (j.cut == 0) && (k == n-1));
      else            drive(j.id, 1'b0, j.p[8*(j.plen-1-(k-j.slen)) +: 8], (j.cut == 0) && (k == n-1));
    end
    @(negedge clk);
    lanes_idle();
    got = 1'b0;
    for (int k = 1; k <= TO + 20; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin got = 1'b1; wc = k; break; end
    end
    chk({tag, " rsp_valid"}, int'(rsp_valid), 1 << j.id);
    if (!got) return;
    chk({tag, " rsp_match"}, int'(rsp_match), j.em);
    chk({tag, " rsp_index"}, int'(rsp_index), j.ei);
    chk({tag, " rsp_err"}, int'(rsp_err), j.ee);
    @(negedge clk);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " rsp_pulse"}, int'(rsp_valid), 0);
    chk({tag, " rsp_err_hold"}, int'(rsp_err), j.ee);
    chk({tag, " str_cycles"}, mon_str - s0, j.fs);
    chk({tag, " pat_cycles"}, mon_pat - p0, j.fp);
    chk({tag, " str_runs"}, mon_rise - r0, (j.fs > 0) ? 1 : 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t tbl [6];
    int wc;
    bit got;

    tbl[0] = mk(0, 5, "ab cd", 2, "cd", 0, 5, 2, 1, 3, 0);
    tbl[1] = mk(1, 0, 0, 1, "b", 0, 0, 1, 1, 1, 1);       // string owned by req0
    tbl[2] = mk(0, 0, 0, 1, "b", 0, 0, 1, 1, 1, 0);       // reuses its own string
    tbl[3] = mk(1, 5, "hello", 3, "xyz", 0, 5, 3, 0, 0, 0);
    tbl[4] = mk(0, 34, "abcdefghijklmnopqrstuvwxyzABCDEFGH", 1, "F", 0, 32, 1, 1, 31, 1);
    tbl[5] = mk(1, 6, "abcdef", 0, 0, 3, 3, 0, 0, 0, 1);  // valid drops after 3

    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous pair from reset: req0 wins, then req1.
    req = 2'b11;
    run_job(mk(0, 2, "xy", 1, "y", 0, 2, 1, 1, 1, 0), "pair1_a", wc);
    run_job(mk(1, 2, "xy", 1, "x", 0, 2, 1, 1, 0, 0), "pair1_b", wc);
    // Lone req0 job leaves the pointer at 1, so the next pair favours req1.
    run_job(mk(0, 2, "pq", 1, "q", 0, 2, 1, 1, 1, 0), "solo0", wc);
    req = 2'b11;
    run_job(mk(1, 2, "pq", 1, "p", 0, 2, 1, 1, 0, 0), "pair2_a", wc);
    run_job(mk(0, 2, "zz", 1, "z", 0, 2, 1, 1, 0, 0), "pair2_b", wc);

    for (int t = 0; t < 6; t++) run_job(tbl[t], $sformatf("tbl%0d", t), wc);

    // Engine silent: response only after the full timeout.
    m_en = 1'b0;
    run_job(mk(0, 3, "abc", 1, "b", 0, 3, 1, 0, 0, 1), "timeout", wc);
    chk("timeout wait_cycles", wc, TO);

    // Reset while waiting for the engine.
    req[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk("rstjob gnt", int'(gnt), 1);
    req[0] = 1'b0;
    @(negedge clk); drive(0, 1'b1, "a", 1'b0);
    @(negedge clk); drive(0, 1'b0, "b", 1'b1);
    @(negedge clk); lanes_idle();
    repeat (3) @(negedge clk);
    chk("rstjob busy_in_wait", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("midjob_reset");
    reset = 1'b0;
    m_en = 1'b1;
    @(negedge clk);

    // After reset: pointer back to 0 and no resident string.
    req = 2'b11;
    run_job(mk(0, 0, 0, 1, "b", 0, 0, 1, 0, 0, 1), "post_a", wc);
    run_job(mk(1, 2, "qq", 1, "q", 0, 2, 1, 1, 0, 0), "post_b", wc);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
